// File: rtl/wfg_record_spi_pkg.sv
// Shared types for the SPI recorder: FSM states, word-size encodings and lookup.
package wfg_record_spi_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DRAIN
    } state_t;

    typedef enum logic [1:0] {
        DFF_8  = 2'b00,
        DFF_16 = 2'b01,
        DFF_24 = 2'b10,
        DFF_32 = 2'b11
    } dff_t;

    // Number of bits per word for a cfg_dff encoding.
    function automatic logic [5:0] word_bits(input logic [1:0] dff);
        case (dff_t'(dff))
            DFF_8:   word_bits = 6'd8;
            DFF_16:  word_bits = 6'd16;
            DFF_24:  word_bits = 6'd24;
            default: word_bits = 6'd32;
        endcase
    endfunction

endpackage

// File: rtl/wfg_record_spi_fifo.sv
// Output word FIFO: 32-bit, power-of-two depth; a push while full is accepted
// only when a pop happens in the same cycle. Output reads zero when empty.
module wfg_record_spi_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        full,
    output logic        empty
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0] mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Read/write pointers with wrap bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/wfg_record_spi.sv
// SPI slave recorder: synchronises an external SPI bus, deserialises 8/16/24/32-bit
// words and streams them out through a small FIFO.
// Optional macro WFG_RECORD_SPI_OVF_CNT_EN adds an 8-bit saturating drop counter.
module wfg_record_spi
    import wfg_record_spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        io_wbs_clk,
    input  logic        io_wbs_rst,
    input  logic        spi_sclk_i,
    input  logic        spi_cs_ni,
    input  logic        spi_sdi_i,
    input  logic        cfg_en_i,
    input  logic        cfg_cpol_i,
    input  logic        cfg_cpha_i,
    input  logic        cfg_lsbfirst_i,
    input  logic [1:0]  cfg_dff_i,
    input  logic        ovf_clr_i,
    output logic [31:0] m_axis_tdata_o,
    output logic        m_axis_tvalid_o,
    input  logic        m_axis_tready_i,
    output logic        ovf_o,
    output logic        frame_err_o
`ifdef WFG_RECORD_SPI_OVF_CNT_EN
    ,
    output logic [7:0]  ovf_cnt_o
`endif
);

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, sdi_sync, sync_vld;
    logic        sclk_s, cs_s, sdi_s, sclk_prev;
    logic        armed;
    logic        sample_edge;
    state_t      state_q, state_d;
    logic        start, shift_en, push, frame_err_set;
    logic        cpol_q, cpha_q, lsb_q;
    logic [1:0]  dff_q;
    logic [5:0]  bit_cnt;
    logic [5:0]  size_q;
    logic [31:0] word_q;
    logic        fifo_full, fifo_empty, pop, drop;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign sdi_s  = sdi_sync[SYNC_STAGES-1];
    assign size_q = word_bits(dff_q);

    // Input synchronisers, preset to an idle bus; sync_vld marks when the
    // pipeline holds real samples rather than reset presets.
    always_ff @(posedge io_wbs_clk) begin
        if (io_wbs_rst) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            sdi_sync  <= '0;
            sync_vld  <= '0;
            sclk_prev <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk_i};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_ni};
            sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], spi_sdi_i};
            sync_vld  <= {sync_vld[SYNC_STAGES-2:0], 1'b1};
            sclk_prev <= sclk_s;
        end
    end

    // After reset a frame may start only once a genuine CS-high has been seen,
    // so a frame interrupted by reset is never picked up half-way.
    always_ff @(posedge io_wbs_clk) begin
        if (io_wbs_rst)                          armed <= 1'b0;
        else if (sync_vld[SYNC_STAGES-1] && cs_s) armed <= 1'b1;
    end

    assign sample_edge = (cpol_q == cpha_q) ? (sclk_s && !sclk_prev)
                                            : (!sclk_s && sclk_prev);

    // FSM state register.
    always_ff @(posedge io_wbs_clk) begin
        if (io_wbs_rst) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    // FSM next state and datapath strobes.
    always_comb begin
        state_d       = state_q;
        start         = 1'b0;
        shift_en      = 1'b0;
        push          = 1'b0;
        frame_err_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_en_i && armed && !cs_s) begin
                    state_d = ST_SHIFT;
                    start   = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (!cfg_en_i) begin
                    state_d = ST_IDLE;
                end else if (cs_s) begin
                    state_d       = ST_IDLE;
                    frame_err_set = (bit_cnt != 6'd0);
                end else if (sample_edge) begin
                    shift_en = 1'b1;
                    if (bit_cnt + 6'd1 == size_q) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                push    = 1'b1;
                state_d = (!cfg_en_i || cs_s) ? ST_IDLE : ST_SHIFT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Frame configuration latch, bit counter and shift register.
    always_ff @(posedge io_wbs_clk) begin
        if (io_wbs_rst) begin
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            lsb_q   <= 1'b0;
            dff_q   <= 2'b00;
            bit_cnt <= '0;
            word_q  <= '0;
        end else if (start) begin
            cpol_q  <= cfg_cpol_i;
            cpha_q  <= cfg_cpha_i;
            lsb_q   <= cfg_lsbfirst_i;
            dff_q   <= cfg_dff_i;
            bit_cnt <= '0;
            word_q  <= '0;
        end else if (shift_en) begin
            if (lsb_q) word_q[bit_cnt[4:0]] <= sdi_s;
            else       word_q <= {word_q[30:0], sdi_s};
            bit_cnt <= bit_cnt + 6'd1;
        end else if (push) begin
            bit_cnt <= '0;
            word_q  <= '0;
        end
    end

    assign pop  = m_axis_tvalid_o && m_axis_tready_i;
    assign drop = push && fifo_full && !pop;

    wfg_record_spi_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (io_wbs_clk),
        .rst   (io_wbs_rst),
        .push  (push),
        .pop   (pop),
        .din   (word_q),
        .dout  (m_axis_tdata_o),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign m_axis_tvalid_o = !fifo_empty;

    // Sticky error flags; a set in the same cycle as a clear wins.
    always_ff @(posedge io_wbs_clk) begin
        if (io_wbs_rst) begin
            ovf_o       <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            if (drop)           ovf_o <= 1'b1;
            else if (ovf_clr_i) ovf_o <= 1'b0;
            if (frame_err_set)  frame_err_o <= 1'b1;
            else if (ovf_clr_i) frame_err_o <= 1'b0;
        end
    end

`ifdef WFG_RECORD_SPI_OVF_CNT_EN
    // Saturating count of dropped words.
    always_ff @(posedge io_wbs_clk) begin
        if (io_wbs_rst) begin
            ovf_cnt_o <= '0;
        end else if (drop) begin
            if (ovf_clr_i)               ovf_cnt_o <= 8'd1;
            else if (ovf_cnt_o != 8'hFF) ovf_cnt_o <= ovf_cnt_o + 8'd1;
        end else if (ovf_clr_i) begin
            ovf_cnt_o <= '0;
        end
    end
`endif

endmodule

// File: doc/wfg_record_spi.md
WFG_RECORD_SPI -- requirements
Module: wfg_record_spi

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, meaning the synchroniser depth for spi_sclk_i, spi_cs_ni and spi_sdi_i (legal values 2..3).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the output word FIFO depth (power of two, 2..16).
REQ-003 The block SHALL have one clock and a synchronous active-high reset: io_wbs_clk  in  1  sole clock; io_wbs_rst  in  1  synchronous active-high reset.
REQ-004 The block SHALL have the port: spi_sclk_i  in  1  external SPI clock, asynchronous to io_wbs_clk.
REQ-005 The block SHALL have the port: spi_cs_ni  in  1  active-low chip select, asynchronous.
REQ-006 The block SHALL have the port: spi_sdi_i  in  1  serial data in, asynchronous.
REQ-007 The block SHALL have the port: cfg_en_i  in  1  receiver enable.
REQ-008 The block SHALL have the port: cfg_cpol_i  in  1  clock idle level.
REQ-009 The block SHALL have the port: cfg_cpha_i  in  1  clock phase.
REQ-010 The block SHALL have the port: cfg_lsbfirst_i  in  1  bit order, 1 = LSB first.
REQ-011 The block SHALL have the port: cfg_dff_i  in  2  word size, 00=8, 01=16, 10=24, 11=32 bits.
REQ-012 The block SHALL have the port: ovf_clr_i  in  1  clears the sticky overflow flag.
REQ-013 The block SHALL have the port: m_axis_tdata_o  out  32  received word, right-aligned, upper bits zero.
REQ-014 The block SHALL have the port: m_axis_tvalid_o  out  1  word available.
REQ-015 The block SHALL have the port: m_axis_tready_i  in  1  downstream accepts the word.
REQ-016 The block SHALL have the port: ovf_o  out  1  sticky flag set when a completed word is dropped.
REQ-017 The block SHALL have the port: frame_err_o  out  1  sticky flag set when CS rises on a partial word; cleared by ovf_clr_i.

Function
REQ-018 All three SPI inputs SHALL pass through SYNC_STAGES flops; all SPI edge detection SHALL use only the synchronised values.
REQ-019 Sample edge: rising synchronised sclk when cfg_cpol_i==cfg_cpha_i, falling otherwise; one bit SHALL be shifted per sample edge.
REQ-020 FSM states SHALL be IDLE, SHIFT and DRAIN: IDLE->SHIFT on synchronised CS low with cfg_en_i=1; SHIFT->DRAIN when the bit count reaches the word size; DRAIN->SHIFT after one cycle (push); SHIFT or DRAIN->IDLE on CS high or cfg_en_i=0.
REQ-021 cfg_cpol_i, cfg_cpha_i, cfg_lsbfirst_i and cfg_dff_i SHALL be latched on the IDLE->SHIFT transition and held for the whole frame.
REQ-022 MSB-first data SHALL fill from the word MSB downward; LSB-first data SHALL fill bit 0 upward.
REQ-023 Back-to-back words SHALL be received within one CS-low frame without gaps; the bit counter SHALL wrap to 0 on each push.
REQ-024 The completed word SHALL be visible on m_axis_tvalid_o/m_axis_tdata_o one cycle after DRAIN if the FIFO was empty.
REQ-025 m_axis_tvalid_o SHALL equal FIFO not-empty; a pop SHALL occur on tvalid&&tready; m_axis_tdata_o SHALL stay stable while tvalid=1 and tready=0.
REQ-026 A push into a full FIFO SHALL be dropped and SHALL set ovf_o, except when a pop occurs in the same cycle, in which case the push SHALL be accepted.
REQ-027 If CS rises with 1..size-1 bits collected, the partial word SHALL be discarded and frame_err_o SHALL be set; CS rising on a word boundary SHALL not be an error.
REQ-028 cfg_en_i=0 SHALL force the FSM to IDLE and discard any partial word, but SHALL retain FIFO contents.
REQ-029 ovf_clr_i SHALL clear both sticky flags; a set event in the same cycle as the clear SHALL win.
REQ-030 Correct operation SHALL require the io_wbs_clk frequency to be at least 4x the sclk frequency.

Reset
REQ-031 io_wbs_rst SHALL put the FSM in IDLE, empty the FIFO, set m_axis_tdata_o=0, m_axis_tvalid_o=0, ovf_o=0, frame_err_o=0, and preset the synchronisers to CS=1, sclk=0, sdi=0.
REQ-032 Reset asserted mid-frame SHALL discard the partial word; the block SHALL wait for CS high before a new frame can start.

Configuration
REQ-033 Macro WFG_RECORD_SPI_OVF_CNT_EN SHALL add output ovf_cnt_o (8 bits, reset 0), which increments on every dropped word, saturates at 255, and is cleared by ovf_clr_i.
REQ-034 Without WFG_RECORD_SPI_OVF_CNT_EN, the ovf_cnt_o port and the counter SHALL be absent.

Structure
REQ-035 Package wfg_record_spi_pkg SHALL hold the FSM state enum, the cfg_dff encodings and the word-size lookup (8/16/24/32).
REQ-036 The FIFO SHALL be the sub-module wfg_record_spi_fifo (parameter DEPTH, 32-bit data, push/pop/full/empty).

Verification
REQ-037 Test mode 0 SHALL cover: dff=00, MSB-first, send 0xA5 -> tdata=0x000000A5 with frame_err_o=0.
REQ-038 Test mode 3 SHALL cover: dff=11, LSB-first, send 0x12345678 as bit0 first -> tdata=0x12345678.
REQ-039 Test back-to-back SHALL cover: dff=01, three words 0x1111/0x2222/0x3333 in one frame with tready=1 -> three beats in order.
REQ-040 Test overflow SHALL cover: tready=0, 5 bytes at FIFO_DEPTH=4 -> 4 held, ovf_o=1, ovf_cnt_o=1 if enabled; drain -> first 4 bytes only.
REQ-041 Test partial frame SHALL cover: CS rises after 5 bits of an 8-bit word -> no tvalid, frame_err_o=1; ovf_clr_i pulse -> 0.
REQ-042 Test reset mid-frame SHALL cover: io_wbs_rst after 4 bits -> all outputs 0; the next clean frame with 0x3C yields 0x3C.
